// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bundle: next-PC mux link, instruction-memory request/response
// channel and the instruction stream toward decode.
// master = fetch stage side, slave = environment (next-PC mux, imem, decode).
interface fetch_pc_stage_if;
  logic [31:0] pc_next_in;
  logic        flush_in;
  logic [31:0] pc_out;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        misalign_out;

  modport master (
    input  pc_next_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in,
           instr_ready_in,
    output pc_out, imem_req_out, imem_addr_out, instr_valid_out, instr_out,
           instr_pc_out, misalign_out
  );

  modport slave (
    output pc_next_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in,
           instr_ready_in,
    input  pc_out, imem_req_out, imem_addr_out, instr_valid_out, instr_out,
           instr_pc_out, misalign_out
  );
endinterface

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: owns the architectural PC, issues one instruction-memory
// fetch at a time and buffers returned words in a small FIFO toward decode.
// A redirect (flush_in) reloads the PC, empties the FIFO and kills any
// response still in flight.
// Optional macro FETCH_MISALIGN_TRAP_EN: suppress fetches from a misaligned
// PC and raise a sticky misalign_out flag until the next redirect.
module fetch_pc_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  fetch_pc_stage_if.master  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             kill_q, kill_d;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_after;
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem    [FIFO_DEPTH];

  logic             pc_bad;
  logic             req;
  logic             gnt_fire;
  logic             rsp_fire;
  logic             push;
  logic             pop;
  logic             head_valid;

  assign head_valid = (count_q != '0);
  assign req        = (state_q == S_REQ) && !pc_bad;
  assign gnt_fire   = req && bus.imem_gnt_in;
  assign rsp_fire   = (state_q == S_WAIT) && bus.imem_rvalid_in;
  // A killed response and any response coinciding with a redirect are dropped.
  assign push       = rsp_fire && !kill_q && !bus.flush_in;
  // The redirect empties the FIFO, so a pop in the same cycle is irrelevant.
  assign pop        = head_valid && bus.instr_ready_in && !bus.flush_in;

  // Occupancy after this cycle's push/pop, used to decide whether to fetch again.
  always_comb begin
    count_after = count_q;
    if (push && !pop) begin
      count_after = count_q + 1'b1;
    end else if (!push && pop) begin
      count_after = count_q - 1'b1;
    end
  end

  // Fetch FSM next-state logic; a redirect overrides the normal transitions.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;

    case (state_q)
      S_IDLE: begin
        if (count_q < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_fire) begin
          pc_d          = bus.pc_next_in;
          inflight_pc_d = pc_q;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid_in) begin
          kill_d  = 1'b0;
          state_d = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush_in) begin
      pc_d = bus.pc_next_in;
      case (state_q)
        S_REQ: begin
          if (gnt_fire) begin
            // Grant is honoured but the returning word belongs to the old path.
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid_in) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            // Stay until the stale response drains so only one request is outstanding.
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // FSM, PC and in-flight bookkeeping registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      pc_q          <= BOOT_ADDR;
      inflight_pc_q <= BOOT_ADDR;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_after;
    end
  end

  // FIFO storage; needs no reset because occupancy gates visibility.
  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata_in;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Request gating guarantees a free slot for every response.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(push && (count_q == DEPTH_C)));
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Sticky misaligned-PC flag: set when about to fetch from a misaligned PC.
  always_comb begin
    misalign_d = misalign_q;
    if (((state_q == S_IDLE) || (state_q == S_REQ)) && (pc_q[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
    if (bus.flush_in) begin
      misalign_d = 1'b0;
    end
  end

  // Misalign flag register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign pc_bad            = (pc_q[1:0] != 2'b00) || misalign_q;
  assign bus.misalign_out  = misalign_q;
  assign bus.imem_addr_out = pc_q;
`else
  assign pc_bad            = 1'b0;
  assign bus.misalign_out  = 1'b0;
  assign bus.imem_addr_out = {pc_q[31:2], 2'b00};
`endif

  assign bus.pc_out          = pc_q;
  assign bus.imem_req_out    = req;
  assign bus.instr_valid_out = head_valid;
  assign bus.instr_out       = instr_mem[rd_ptr_q];
  assign bus.instr_pc_out    = pc_mem[rd_ptr_q];

endmodule
